// File: rtl/octree_mem_pkg.sv
// Shared types and helpers for the Octree memory subsystem: FSM state encoding,
// index-width helper and the mem multiplexer select codes.
package octree_mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_state_e;

    // Select codes used by the mem multiplexer above the responder.
    localparam logic [1:0] NAN      = 2'd0;
    localparam logic [1:0] SEARCHER = 2'd1;
    localparam logic [1:0] UPDATER  = 2'd2;

    // Word-index width for a memory of the given depth.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Single-port mem_sram bus between the Octree initiator and the SRAM responder.
interface sram_responder_if #(
    parameter int DATA_BUS_WIDTH = 64,
    parameter int ADDR_BUS_WIDTH = 64
);
    logic                      mem_sram_CEN;
    logic [ADDR_BUS_WIDTH-1:0] mem_sram_A;
    logic [DATA_BUS_WIDTH-1:0] mem_sram_D;
    logic                      mem_sram_GWEN;
    logic [DATA_BUS_WIDTH-1:0] mem_sram_Q;
    logic                      q_valid;

    modport master (
        output mem_sram_CEN,
        output mem_sram_A,
        output mem_sram_D,
        output mem_sram_GWEN,
        input  mem_sram_Q,
        input  q_valid
    );

    modport slave (
        input  mem_sram_CEN,
        input  mem_sram_A,
        input  mem_sram_D,
        input  mem_sram_GWEN,
        output mem_sram_Q,
        output q_valid
    );
endinterface

// File: rtl/sram_rd_pipe.sv
// Read-return shift register carrying {valid, data}; every stage holds its data
// while no valid word passes, so the last stage doubles as the held Q register.
module sram_rd_pipe #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic             vld_q;
            logic             vld_d;
            logic [WIDTH-1:0] dat_q;
            logic [WIDTH-1:0] dat_d;
            logic             prev_vld;
            logic [WIDTH-1:0] prev_dat;

            if (gi == 0) begin : g_head
                assign prev_vld = in_valid;
                assign prev_dat = in_data;
            end else begin : g_link
                assign prev_vld = g_stage[gi-1].vld_q;
                assign prev_dat = g_stage[gi-1].dat_q;
            end

            always_comb begin
                vld_d = prev_vld;
                dat_d = dat_q;
                if (prev_vld) begin
                    dat_d = prev_dat;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[LATENCY-1].vld_q;
    assign out_data  = g_stage[LATENCY-1].dat_q;

endmodule

// File: rtl/sram_responder.sv
// Register-backed SRAM responder: clear sweep after reset/clear_req, registered
// array read feeding a fixed-latency return pipe, saturating access counters.
module sram_responder
    import octree_mem_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 64,
    parameter int ADDR_BUS_WIDTH = 64,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_responder_if.slave      bus,
    input  logic                 clear_req,
    output logic                 init_busy,
    output logic                 addr_err,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    localparam int IDX_W = idx_w(DEPTH);

    mem_state_e state_q, state_d;
    logic [IDX_W-1:0]     clr_ptr_q, clr_ptr_d;
    logic                 addr_err_q, addr_err_d;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic                 rd_req_q, rd_req_d;
    logic                 rd_oor_q, rd_oor_d;

    logic [DATA_BUS_WIDTH-1:0] mem [DEPTH];
    logic [DATA_BUS_WIDTH-1:0] rd_data_q;

    logic                      mem_we;
    logic [IDX_W-1:0]          mem_waddr;
    logic [DATA_BUS_WIDTH-1:0] mem_wdata;
    logic                      rd_en;

    logic                      access;
    logic                      in_range;
    logic [IDX_W-1:0]          acc_idx;

    logic                      pipe_in_valid;
    logic [DATA_BUS_WIDTH-1:0] pipe_in_data;
    logic                      pipe_out_valid;
    logic [DATA_BUS_WIDTH-1:0] pipe_out_data;

    assign access   = ~bus.mem_sram_CEN;
    // Any set bit above the index field puts the address past the array.
    assign in_range = (bus.mem_sram_A[ADDR_BUS_WIDTH-1:IDX_W] == '0);
    assign acc_idx  = bus.mem_sram_A[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        addr_err_d = addr_err_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        rd_req_d   = 1'b0;
        rd_oor_d   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr_q;
        mem_wdata  = '0;
        rd_en      = 1'b0;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (access) begin
                    if (!bus.mem_sram_GWEN) begin
                        if (wr_cnt_q != '1) begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                        if (in_range) begin
                            mem_we    = 1'b1;
                            mem_waddr = acc_idx;
                            mem_wdata = bus.mem_sram_D;
                        end
                    end else begin
                        if (rd_cnt_q != '1) begin
                            rd_cnt_d = rd_cnt_q + 1'b1;
                        end
                        rd_req_d = 1'b1;
                        rd_oor_d = ~in_range;
                        rd_en    = in_range;
                    end
                    if (!in_range) begin
                        addr_err_d = 1'b1;
                    end
                end
                // The access above is still taken; the sweep starts next cycle.
                if (clear_req) begin
                    state_d    = INIT;
                    clr_ptr_d  = '0;
                    addr_err_d = 1'b0;
                end
            end
            default: begin
                state_d   = INIT;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            clr_ptr_q  <= '0;
            addr_err_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rd_req_q   <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            addr_err_q <= addr_err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_req_q   <= rd_req_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    // Array and its registered read port carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[acc_idx];
        end
    end

    assign pipe_in_valid = rd_req_q;
    assign pipe_in_data  = rd_oor_q ? '0 : rd_data_q;

    sram_rd_pipe #(
        .WIDTH   (DATA_BUS_WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pipe_in_valid),
        .in_data   (pipe_in_data),
        .out_valid (pipe_out_valid),
        .out_data  (pipe_out_data)
    );

    assign bus.mem_sram_Q = pipe_out_data;
    assign bus.q_valid    = pipe_out_valid;
    assign init_busy      = (state_q == INIT);
    assign addr_err       = addr_err_q;
    assign rd_count       = rd_cnt_q;
    assign wr_count       = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus random bench for sram_responder (DEPTH=16, READ_LATENCY=3,
// CNT_WIDTH=4) against a queue-based behavioural memory model.
module tb_sram_responder;

    localparam int DW    = 64;
    localparam int AW    = 64;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_req = 1'b0;
    logic          init_busy;
    logic          addr_err;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;

    sram_responder_if #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) bus ();

    sram_responder #(
        .DATA_BUS_WIDTH (DW),
        .ADDR_BUS_WIDTH (AW),
        .DEPTH          (DEPTH),
        .READ_LATENCY   (LAT),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .clear_req (clear_req),
        .init_busy (init_busy),
        .addr_err  (addr_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rd_t;

    logic [63:0] ref_mem [DEPTH];
    rd_t         pend [$];
    bit          m_init;
    int          m_ptr;
    bit          m_err;
    int          m_rd;
    int          m_wr;
    logic [63:0] m_q;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_v);
        chk("q_valid", {63'd0, bus.q_valid}, {63'd0, exp_v});
        chk("Q", bus.mem_sram_Q, m_q);
        chk("init_busy", {63'd0, init_busy}, {63'd0, m_init});
        chk("addr_err", {63'd0, addr_err}, {63'd0, m_err});
        chk("rd_count", 64'(rd_count), 64'(m_rd));
        chk("wr_count", 64'(wr_count), 64'(m_wr));
    endtask

    // One clock: drive inputs, update the model at the edge, compare at the falling edge.
    task automatic step(input logic cen, input logic [63:0] a, input logic [63:0] d,
                        input logic gwen, input logic clr);
        logic exp_v;
        bus.mem_sram_CEN  = cen;
        bus.mem_sram_A    = a;
        bus.mem_sram_D    = d;
        bus.mem_sram_GWEN = gwen;
        clear_req         = clr;
        @(posedge clk);
        cyc++;
        if (m_init) begin
            ref_mem[m_ptr] = 64'd0;
            m_ptr++;
            if (m_ptr == DEPTH) m_init = 1'b0;
        end else begin
            if (!cen) begin
                if (a < DEPTH) begin
                    if (!gwen) ref_mem[a[3:0]] = d;
                    else pend.push_back('{due: cyc + LAT, data: ref_mem[a[3:0]]});
                end else begin
                    m_err = 1'b1;
                    if (gwen) pend.push_back('{due: cyc + LAT, data: 64'd0});
                end
                if (gwen) m_rd = (m_rd < CMAX) ? m_rd + 1 : CMAX;
                else      m_wr = (m_wr < CMAX) ? m_wr + 1 : CMAX;
            end
            if (clr) begin
                m_init = 1'b1;
                m_ptr  = 0;
                m_err  = 1'b0;
            end
        end
        @(negedge clk);
        exp_v = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_v = 1'b1;
            m_q   = pend[0].data;
            void'(pend.pop_front());
        end
        check_outputs(exp_v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 64'd0, 64'd0, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        step(1'b0, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [63:0] a);
        step(1'b0, a, 64'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_sram_CEN = 1'b1;
        clear_req = 1'b0;
        pend.delete();
        m_init = 1'b1;
        m_ptr  = 0;
        m_err  = 1'b0;
        m_rd   = 0;
        m_wr   = 0;
        m_q    = 64'd0;
        repeat (2) @(negedge clk);
        check_outputs(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bus.mem_sram_CEN  = 1'b1;
        bus.mem_sram_A    = '0;
        bus.mem_sram_D    = '0;
        bus.mem_sram_GWEN = 1'b1;
        cyc = 0;

        // Reset sweep, then a read of the cleared array.
        do_reset();
        idle(DEPTH - 1);
        chk("sweep_last_busy", {63'd0, init_busy}, 64'd1);
        idle(1);
        chk("sweep_done", {63'd0, init_busy}, 64'd0);
        rd(64'd5);
        idle(LAT);

        // Write then immediate read-back.
        wr(64'd3, 64'hDEAD_BEEF_0000_0001);
        rd(64'd3);
        idle(LAT);
        chk("wb_q", bus.mem_sram_Q, 64'hDEAD_BEEF_0000_0001);
        chk("wb_wr_count", 64'(wr_count), 64'd1);

        // Back-to-back reads.
        wr(64'd0, 64'd10);
        wr(64'd1, 64'd11);
        wr(64'd2, 64'd12);
        rd(64'd0);
        rd(64'd1);
        rd(64'd2);
        idle(LAT + 1);
        chk("pipe_last_q", bus.mem_sram_Q, 64'd12);

        // Out-of-range write/read, including an upper-bit-only address.
        wr(64'd16, 64'h55);
        rd(64'd16);
        rd(64'd0);
        rd(64'h0000_0100_0000_0003);
        idle(LAT + 1);
        chk("oor_err", {63'd0, addr_err}, 64'd1);
        chk("oor_word0", bus.mem_sram_Q, 64'd0);

        // clear_req, then a write during the sweep that must be dropped.
        step(1'b1, 64'd0, 64'd0, 1'b1, 1'b1);
        chk("clr_err", {63'd0, addr_err}, 64'd0);
        wr(64'd2, 64'h99);
        step(1'b1, 64'd0, 64'd0, 1'b1, 1'b1);
        idle(DEPTH - 2);
        chk("clr_sweep_done", {63'd0, init_busy}, 64'd0);
        rd(64'd2);
        idle(LAT);
        chk("init_write_dropped", bus.mem_sram_Q, 64'd0);

        // Reset while a read is in flight.
        wr(64'd7, 64'h1234);
        rd(64'd7);
        do_reset();
        idle(LAT + DEPTH);

        // Counter saturation.
        for (int i = 0; i < 20; i++) rd(64'($urandom_range(0, DEPTH - 1)));
        idle(LAT);
        chk("rd_sat", 64'(rd_count), 64'd15);

        // Random traffic with occasional clears and out-of-range addresses.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a;
            a = 64'($urandom_range(0, DEPTH + 4));
            if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
            step(($urandom_range(0, 3) == 0), a, {$urandom, $urandom},
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
        end
        idle(LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
